// File: rtl/mul_product_round_sat.sv
// mul_product_round_sat
// Output stage behind the unsigned N x N multiplier array. It rounds the
// 2N-bit product (round-half-up, drop FRAC LSBs), saturates to OUT_W bits
// and presents the result through a 2-deep elastic pipeline (S1 = rounded
// value, S2 = output registers). It also keeps a sticky 16-bit count of
// saturated results that were handed off downstream.
module mul_product_round_sat #(
  parameter int N     = 24,
  parameter int FRAC  = 23,
  parameter int OUT_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*N-1:0]     in_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_q,
  output logic               out_sat,
  input  logic               clr_stats,
  output logic [15:0]        sat_count
);

  localparam int PW = 2 * N;

  // Rounding constant 2^(FRAC-1). Shifting a one up by FRAC and back down by
  // one gives zero when FRAC is 0, so the same add covers "no rounding".
  localparam logic [PW:0] RND = ({{PW{1'b0}}, 1'b1} << FRAC) >> 1;

  // True when the rounded value does not fit in OUT_W bits.
  function automatic logic is_over(input logic [PW:0] r);
    return |r[PW:OUT_W];
  endfunction

  // One extra bit of headroom so the rounding add never overflows.
  logic [PW:0]      w_sum;
  logic [PW:0]      w_rnd;
  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_fire;
  logic             w_out_fire;

  logic             r_s1_valid;
  logic [PW:0]      r_s1_val;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_q;
  logic             r_out_sat;
  logic [15:0]      r_sat_count;

  // Rounding datapath and handshake qualifiers.
  always_comb begin
    w_sum      = {1'b0, in_p} + RND;
    w_rnd      = w_sum >> FRAC;
    w_s2_adv   = !r_out_valid || out_ready;
    w_s1_adv   = r_s1_valid && w_s2_adv;
    w_in_fire  = in_valid && in_ready;
    w_out_fire = r_out_valid && out_ready;
  end

  // Stage can take a product when S1 is empty or S1 moves forward this cycle.
  assign in_ready = !rst && (!r_s1_valid || w_s2_adv);

  // S1: capture the rounded product on accept, empty it when it moves to S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_val   <= w_rnd;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= r_s1_valid;
    end
  end

  // S2: saturate and hold the result until downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_q     <= {OUT_W{1'b0}};
      r_out_sat   <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      if (is_over(r_s1_val)) begin
        r_out_q   <= {OUT_W{1'b1}};
        r_out_sat <= 1'b1;
      end else begin
        r_out_q   <= r_s1_val[OUT_W-1:0];
        r_out_sat <= 1'b0;
      end
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Sticky saturation statistic; clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_count <= 16'h0000;
    end else if (clr_stats) begin
      r_sat_count <= 16'h0000;
    end else if (w_out_fire && r_out_sat && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'h0001;
    end else begin
      r_sat_count <= r_sat_count;
    end
  end

  assign out_valid = r_out_valid;
  assign out_q     = r_out_q;
  assign out_sat   = r_out_sat;
  assign sat_count = r_sat_count;

endmodule

// File: tb/tb_mul_product_round_sat.sv
// Self-checking bench for mul_product_round_sat. Expected results come from
// a queue-based model: every accepted product is rounded/saturated with plain
// 64-bit arithmetic and becomes visible two cycles after acceptance once it
// reaches the head of the queue; at most two products are in flight.
module tb_mul_product_round_sat;

  localparam int N     = 24;
  localparam int FRAC  = 23;
  localparam int OUT_W = 24;
  localparam int PW    = 2 * N;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [PW-1:0]     in_p;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_q;
  logic              out_sat;
  logic              clr_stats;
  logic [15:0]       sat_count;

  mul_product_round_sat #(.N(N), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_sat   (out_sat),
    .clr_stats (clr_stats),
    .sat_count (sat_count)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] q;
    logic             sat;
    int               t;
  } item_t;

  item_t       sb[$];
  int          cyc;
  int unsigned m_cnt;
  int          n_tests;
  int          n_fail;
  logic        f_in;
  logic        f_out;
  logic        f_out_sat;
  logic [OUT_W-1:0] f_out_q;

  // Count one comparison and report it if it does not match.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference rounding/saturation with plain wide arithmetic.
  function automatic item_t ref_item(input logic [PW-1:0] p, input int t);
    item_t           it;
    longint unsigned r;
    r = (longint'(p) + (64'd1 << (FRAC - 1))) >> FRAC;
    it.t = t;
    if (r >= (64'd1 << OUT_W)) begin
      it.sat = 1'b1;
      it.q   = '1;
    end else begin
      it.sat = 1'b0;
      it.q   = OUT_W'(r);
    end
    return it;
  endfunction

  // One clock cycle: drive at negedge, sample 1 ns later, check, update model.
  task automatic cycle(input logic iv, input logic [PW-1:0] p, input logic ordy,
                       input logic clr, input logic rs);
    logic exp_ready;
    logic exp_ov;
    @(negedge clk);
    in_valid  = iv;
    in_p      = p;
    out_ready = ordy;
    clr_stats = clr;
    rst       = rs;
    #1;
    f_in      = 1'b0;
    f_out     = 1'b0;
    f_out_sat = 1'b0;
    if (rs) begin
      chk("in_ready_in_rst", in_ready, 0);
      sb.delete();
      m_cnt = 0;
    end else begin
      exp_ready = !((sb.size() == 2) && !ordy);
      exp_ov    = (sb.size() > 0) && (cyc >= sb[0].t + 2);
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("out_q", out_q, sb[0].q);
        chk("out_sat", out_sat, sb[0].sat);
      end
      chk("sat_count", sat_count, m_cnt);
      f_in  = iv && exp_ready;
      f_out = exp_ov && ordy;
      if (f_out) begin
        f_out_sat = sb[0].sat;
        f_out_q   = sb[0].q;
        void'(sb.pop_front());
      end
      if (clr) m_cnt = 0;
      else if (f_out_sat && m_cnt < 32'hFFFF) m_cnt++;
      if (f_in) sb.push_back(ref_item(p, cyc));
    end
    cyc++;
  endtask

  // Present one product with downstream ready, bounded wait for accept.
  task automatic send(input logic [PW-1:0] p);
    int k;
    k = 0;
    do begin
      cycle(1'b1, p, 1'b1, 1'b0, 1'b0);
      k++;
    end while (!f_in && k < 10);
    chk("send_accept_timeout", f_in, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, {16'($urandom), 32'($urandom)}, 1'b1, 1'b0, 1'b0);
  endtask

  // Global safety net.
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    int          acc;
    int          outs;
    int          sat_outs;
    int          last_t;
    logic [OUT_W-1:0] got[$];
    logic [PW-1:0]    rp;
    logic             riv;
    logic             rrd;

    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    m_cnt     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_p      = '0;
    out_ready = 1'b0;
    clr_stats = 1'b0;

    // Reset state.
    cycle(1'b0, 48'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 48'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 48'h0, 1'b1, 1'b0, 1'b0);
    chk("reset_out_q", out_q, 0);
    chk("reset_out_sat", out_sat, 0);
    chk("reset_sat_count", sat_count, 0);

    // Rounding edges and saturation boundary.
    send(48'h000000400000); idle(3);
    send(48'h0000003FFFFF); idle(3);
    send(48'h7FFFFF800000); idle(3);
    send(48'h7FFFFFC00000); idle(3);
    chk("sat_count_after_first_sat", sat_count, 1);
    send(48'hFFFFFE000001); idle(3);
    chk("sat_count_after_max", sat_count, 2);

    // Backpressure: downstream stalled for 5 cycles.
    k = 0; acc = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 48'(k + 1) << FRAC, 1'b0, 1'b0, 1'b0);
      if (f_in) begin k++; acc++; end
    end
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_q_held", out_q, 1);
    outs = 0; last_t = -10;
    got.delete();
    for (int i = 0; i < 12 && !(outs == 3 && k == 3); i++) begin
      cycle(k < 3, 48'(k + 1) << FRAC, 1'b1, 1'b0, 1'b0);
      if (f_in) k++;
      if (f_out) begin
        if (outs > 0) chk("bp_consecutive", cyc - last_t, 1);
        last_t = cyc;
        got.push_back(f_out_q);
        outs++;
      end
    end
    chk("bp_out_count", outs, 3);
    for (int i = 0; i < got.size(); i++) chk("bp_order", got[i], i + 1);

    // Randomized traffic near and away from the saturation boundary.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rp = {16'($urandom), 32'($urandom)};
        1:       rp = 48'h7FFFFF800000 + 48'($urandom_range(0, 32'h00800000));
        2:       rp = 48'($urandom_range(0, 32'h00FFFFFF));
        default: rp = 48'($urandom) << $urandom_range(0, 16);
      endcase
      riv = ($urandom_range(0, 3) != 0);
      rrd = ($urandom_range(0, 3) != 0);
      cycle(riv, rp, rrd, ($urandom_range(0, 99) == 0), 1'b0);
    end
    idle(4);

    // Sticky statistic: more than 0xFFFF saturating hand-offs.
    cycle(1'b0, 48'h0, 1'b1, 1'b1, 1'b0);
    sat_outs = 0;
    for (int i = 0; i < 70000 && sat_outs < 32'h10002; i++) begin
      cycle(1'b1, 48'hFFFFFE000001, 1'b1, 1'b0, 1'b0);
      if (f_out_sat) sat_outs++;
    end
    chk("stats_handoffs", sat_outs, 32'h10002);
    cycle(1'b0, 48'h0, 1'b0, 1'b0, 1'b0);
    chk("stats_sticky", sat_count, 16'hFFFF);
    // Clear coincident with a saturating hand-off.
    cycle(1'b0, 48'h0, 1'b1, 1'b1, 1'b0);
    chk("clr_with_handoff", f_out_sat, 1);
    cycle(1'b0, 48'h0, 1'b0, 1'b0, 1'b0);
    chk("clr_wins", sat_count, 0);
    idle(4);

    // Reset mid-stream with both stages full.
    for (int i = 0; i < 3; i++) cycle(1'b1, 48'd5 << FRAC, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_full", in_ready, 0);
    cycle(1'b1, 48'd7 << FRAC, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 48'h0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_sat_count", sat_count, 0);
    send(48'd9 << FRAC);
    cycle(1'b0, 48'h0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_latency_early", out_valid, 0);
    cycle(1'b0, 48'h0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_latency", out_valid, 1);
    chk("post_rst_value", out_q, 9);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_product_round_sat.md
Name: mul_product_round_sat

Overview:
- Registered output stage that sits directly downstream of the unsigned N x N carry-save multiplier array.
- Accepts the 2N-bit product over a valid/ready handshake and rounds it to the fixed-point output format (right shift by FRAC, round-half-up).
- Saturates to OUT_W bits and presents the result through a 2-deep elastic pipeline.
- Keeps a sticky saturation statistic for software.

Parameters:
- N, 24: multiplier operand width; product input is 2N bits, unsigned.
- FRAC, 23: number of fractional LSBs dropped by rounding; legal 0..2N-1; FRAC=0 means no rounding.
- OUT_W, 24: result width; legal 1..2N.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  product valid from multiplier side
- in_ready  out  1  stage can accept the product this cycle
- in_p  in  2N  unsigned product (top carry already discarded upstream)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_q  out  OUT_W  rounded, saturated result
- out_sat  out  1  this result was clamped
- clr_stats  in  1  synchronous clear of sat_count
- sat_count  out  16  number of saturated results handed off

Behaviour:
- One clock domain (clk). rst is synchronous and active-high.
- Reset values: out_valid=0, out_q=0, out_sat=0, sat_count=0, both internal valids=0. in_ready=0 while rst=1.
- Stage 1 (S1), registered on accept:
  - r = (in_p + 2^(FRAC-1)) >> FRAC, computed in 2N+1 bits, so there is no overflow for any in_p.
  - If FRAC=0, r = in_p.
- Stage 2 (S2 = output regs):
  - If r >= 2^OUT_W: out_q = all ones, out_sat=1.
  - Otherwise: out_q = r[OUT_W-1:0], out_sat=0.
- Handshakes:
  - Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready.
  - s2_adv = !out_valid || out_ready.
  - s1_adv = S1 valid && s2_adv.
  - in_ready = !rst && (!S1 valid || s2_adv). This is combinational from out_ready; there is no path from in_valid.
- Latency: exactly 2 cycles from input handshake to out_valid with no stall. Throughput is 1 per cycle.
- Stall rules:
  - While out_valid && !out_ready, out_q and out_sat hold stable.
  - At most 2 products are buffered. in_ready=0 when both stages are full and out_ready=0.
  - No loss, duplication or reordering.
- Simultaneous accept and hand-off in the same cycle is legal and keeps full throughput.
- sat_count:
  - Increments by 1 on each output handshake with out_sat=1.
  - Saturates at 0xFFFF (no wrap).
  - clr_stats=1 sets it to 0 next cycle and wins over a coincident increment.
- Reset mid-operation: all buffered results are discarded and out_valid drops next cycle. Data registers need not be cleared beyond out_q/out_sat.
- in_p is sampled only on input handshake; X on in_p while in_valid=0 must not propagate.

Test Plan (N=24, FRAC=23, OUT_W=24):
- Rounding edge:
  - in_p=0x000000400000 -> out_q=0x000001, out_sat=0, out_valid exactly 2 cycles after accept.
  - in_p=0x0000003FFFFF -> out_q=0x000000.
- Saturation boundary:
  - in_p=0x7FFFFF800000 -> out_q=0xFFFFFF, out_sat=0.
  - in_p=0x7FFFFFC00000 -> out_q=0xFFFFFF, out_sat=1, sat_count=1.
- Max product: in_p=0xFFFFFE000001 -> out_q=0xFFFFFF, out_sat=1, no width overflow in rounding add.
- Backpressure:
  - Setup: out_ready=0 for 5 cycles while in_valid=1 with products 1<<23, 2<<23, 3<<23.
  - Expected: exactly 2 accepted, then in_ready=0, out_q=1 held.
  - On release: outputs 1, 2, 3 in order on consecutive cycles.
- Stats:
  - Drive 0x10000 saturating results; sat_count sticks at 0xFFFF.
  - Assert clr_stats in the same cycle as a saturating hand-off; sat_count=0 next cycle.
- Reset mid-stream: with both stages full, pulse rst for 1 cycle -> out_valid=0, in_ready=0 during rst, sat_count=0, next accepted product appears with normal 2-cycle latency.
